// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA timing generator: pattern modes,
// the colour-bar table and raster geometry derivations.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_BLACK = 2'd3
    } vga_mode_e;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int coord_width(input int total);
        return $clog2(total);
    endfunction

    // {r,g,b} on/off bits, left to right: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] bits;
        bits = 3'b000;
        case (idx)
            3'd0: bits = 3'b111;
            3'd1: bits = 3'b110;
            3'd2: bits = 3'b011;
            3'd3: bits = 3'b010;
            3'd4: bits = 3'b101;
            3'd5: bits = 3'b100;
            3'd6: bits = 3'b001;
            default: bits = 3'b000;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register used to re-align raster timing with the
// pixel source latency; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_inputs;
            assign unused_inputs = ^{clock, reset_n, en_i};
            assign q_o = d_i;
        end else begin : g_shift
            logic [W-1:0] stage_q [DEPTH];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: counters, pixel request, latency-matched
// sync, built-in test patterns and a registered output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 1,
    parameter int COLOR_W  = 4,
    parameter int PIX_LAT  = 1,
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW      = coord_width(H_TOTAL),
    localparam int YW      = coord_width(V_TOTAL)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         io_mode,
    output logic               io_req_valid,
    output logic [XW-1:0]      io_req_x,
    output logic [YW-1:0]      io_req_y,
    input  logic [COLOR_W-1:0] io_pix_r,
    input  logic [COLOR_W-1:0] io_pix_g,
    input  logic [COLOR_W-1:0] io_pix_b,
    output logic [COLOR_W-1:0] io_vga_r,
    output logic [COLOR_W-1:0] io_vga_g,
    output logic [COLOR_W-1:0] io_vga_b,
    output logic               io_vga_hsync,
    output logic               io_vga_vsync,
    output logic               io_vga_de,
    output logic               io_frame_start
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int CNT_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int PIPE_W = 5 + XW + YW;
    localparam int RGB_W  = 3 * COLOR_W;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [XW-1:0]    h_q, h_d;
    logic [YW-1:0]    v_q, v_d;
    vga_mode_e        mode_q, mode_sel;
    logic             active, hs_act, vs_act;

    logic [PIPE_W-1:0] pipe_in, pipe_out;
    logic              d_active, d_hs, d_vs;
    logic [1:0]        d_mode;
    logic [XW-1:0]     d_h;
    logic [YW-1:0]     d_v;

    logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d, bar_cnt_cur;
    logic [2:0]       bar_idx_q, bar_idx_d, bar_idx_cur;
    logic [2:0]       bar_bits;
    logic [RGB_W-1:0] colour, rgb_q;
    logic             hsync_q, vsync_q, de_q, frame_start_q;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == XW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == YW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    assign active = (h_q < XW'(H_ACTIVE)) && (v_q < YW'(V_ACTIVE));
    assign hs_act = (h_q >= XW'(H_ACTIVE + H_FP)) && (h_q < XW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act = (v_q >= YW'(V_ACTIVE + V_FP)) && (v_q < YW'(V_ACTIVE + V_FP + V_SYNC));

    assign io_req_valid = tick & active;
    assign io_req_x     = h_q;
    assign io_req_y     = v_q;

    // Each pixel carries the mode of its own frame, so a sample at the wrap applies to pixel (0,0).
    assign mode_sel = (tick && h_q == '0 && v_q == '0) ? vga_mode_e'(io_mode) : mode_q;
    assign pipe_in  = {active, hs_act, vs_act, mode_sel, h_q, v_q};
    assign {d_active, d_hs, d_vs, d_mode, d_h, d_v} = pipe_out;

    vga_delay_line #(
        .W     (PIPE_W),
        .DEPTH (PIX_LAT)
    ) u_align (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (tick),
        .d_i     (pipe_in),
        .q_o     (pipe_out)
    );

    // Bar index tracks the delayed column by counting bar widths; column 0 restarts it.
    always_comb begin
        bar_cnt_cur = (d_h == '0) ? '0 : bar_cnt_q;
        bar_idx_cur = (d_h == '0) ? '0 : bar_idx_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        if (tick) begin
            if (bar_cnt_cur == CNT_W'(BAR_W - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_cur + 1'b1;
            end else begin
                bar_cnt_d = bar_cnt_cur + 1'b1;
                bar_idx_d = bar_idx_cur;
            end
        end
    end

    assign bar_bits = bar_rgb(bar_idx_cur);

    always_comb begin
        colour = '0;
        case (vga_mode_e'(d_mode))
            MODE_EXT:  colour = {io_pix_r, io_pix_g, io_pix_b};
            MODE_BARS: colour = {{COLOR_W{bar_bits[2]}}, {COLOR_W{bar_bits[1]}}, {COLOR_W{bar_bits[0]}}};
            MODE_GRID: colour = (d_h[3:0] == 4'd0 || d_v[3:0] == 4'd0) ? '1 : '0;
            default:   colour = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            mode_q        <= MODE_EXT;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            mode_q        <= mode_sel;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            frame_start_q <= tick && d_active && d_h == '0 && d_v == '0;
            if (tick) begin
                rgb_q   <= d_active ? colour : '0;
                de_q    <= d_active;
                hsync_q <= d_hs ? HS_POL : ~HS_POL;
                vsync_q <= d_vs ? VS_POL : ~VS_POL;
            end
        end
    end

    assign {io_vga_r, io_vga_g, io_vga_b} = rgb_q;
    assign io_vga_hsync   = hsync_q;
    assign io_vga_vsync   = vsync_q;
    assign io_vga_de      = de_q;
    assign io_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster, compared every
// clock against a frame/pixel-index reference model.
module tb_vga_timing_gen;

    localparam int HA = 64, HF = 8, HS = 16, HB = 8;
    localparam int VA = 20, VF = 2, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int DIV = 2, LAT = 2, CW = 4;
    localparam int XW = $clog2(HT), YW = $clog2(VT);
    localparam int VW = 1 + XW + YW + 3 * CW + 4;
    localparam logic [11:0] BAR_TAB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic          clock, reset_n;
    logic [1:0]    io_mode;
    logic          io_req_valid;
    logic [XW-1:0] io_req_x;
    logic [YW-1:0] io_req_y;
    logic [CW-1:0] io_pix_r, io_pix_g, io_pix_b;
    logic [CW-1:0] io_vga_r, io_vga_g, io_vga_b;
    logic          io_vga_hsync, io_vga_vsync, io_vga_de, io_frame_start;

    int         compared, mismatched;
    int         edgeCnt;
    logic [1:0] frameMode [64];
    logic [3:0] salt;
    logic [11:0] srcPipe [LAT];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(DIV), .COLOR_W(CW), .PIX_LAT(LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .io_mode(io_mode),
        .io_req_valid(io_req_valid), .io_req_x(io_req_x), .io_req_y(io_req_y),
        .io_pix_r(io_pix_r), .io_pix_g(io_pix_g), .io_pix_b(io_pix_b),
        .io_vga_r(io_vga_r), .io_vga_g(io_vga_g), .io_vga_b(io_vga_b),
        .io_vga_hsync(io_vga_hsync), .io_vga_vsync(io_vga_vsync),
        .io_vga_de(io_vga_de), .io_frame_start(io_frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge count since reset release; records the mode driven at each frame's first counter tick.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            edgeCnt <= 0;
        end else begin
            edgeCnt <= edgeCnt + 1;
            if ((edgeCnt + 1) % DIV == 0 && (((edgeCnt + 1) / DIV - 1) % FT) == 0
                && (((edgeCnt + 1) / DIV - 1) / FT) < 64)
                frameMode[((edgeCnt + 1) / DIV - 1) / FT] <= io_mode;
        end
    end

    function automatic logic [11:0] srcPix(input int x, input int y);
        return {4'(x), 4'(y), 4'(x + y) ^ salt};
    endfunction

    // External pixel source: answers each request LAT ticks later, junk when not requested.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) srcPipe[i] <= '0;
        end else if ((edgeCnt + 1) % DIV == 0) begin
            srcPipe[0] <= io_req_valid ? srcPix(int'(io_req_x), int'(io_req_y)) : 12'($urandom);
            for (int i = 1; i < LAT; i++) srcPipe[i] <= srcPipe[i-1];
        end
    end
    assign {io_pix_r, io_pix_g, io_pix_b} = srcPipe[LAT-1];

    function automatic logic [VW-1:0] dutVec();
        return {io_req_valid, io_req_x, io_req_y, io_vga_r, io_vga_g, io_vga_b,
                io_vga_hsync, io_vga_vsync, io_vga_de, io_frame_start};
    endfunction

    // Expected pins after edge e: the output shows pixel index (ticks - 1 - LAT) of the raster.
    function automatic logic [VW-1:0] modelVec(input int e);
        int k, p, h, v, f;
        logic valid, hsv, vsv, de, fs;
        logic [11:0] rgb;
        k     = e / DIV;
        valid = ((e + 1) % DIV == 0) && (k % HT < HA) && ((k / HT) % VT < VA);
        rgb = '0; hsv = 1'b1; vsv = 1'b1; de = 1'b0; fs = 1'b0;
        p = k - 1 - LAT;
        if (p >= 0) begin
            h   = p % HT;
            v   = (p / HT) % VT;
            f   = p / FT;
            de  = (h < HA) && (v < VA);
            hsv = !(h >= HA + HF && h < HA + HF + HS);
            vsv = !(v >= VA + VF && v < VA + VF + VS);
            fs  = (e % DIV == 0) && (p % FT == 0);
            if (de && f < 64) begin
                case (frameMode[f])
                    2'd0: rgb = srcPix(h, v);
                    2'd1: rgb = BAR_TAB[h / (HA / 8)];
                    2'd2: rgb = (h % 16 == 0 || v % 16 == 0) ? 12'hFFF : 12'h000;
                    default: rgb = 12'h000;
                endcase
            end
        end
        return {valid, XW'(k % HT), YW'((k / HT) % VT), rgb, hsv, vsv, de, fs};
    endfunction

    task automatic test_reset();
        int n;
        logic [VW-1:0] got, exp;
        reset_n = 1'b0;
        io_mode = 2'd1;
        repeat (3) begin
            @(negedge clock);
            compared++;
            if ({io_vga_hsync, io_vga_vsync, io_vga_de, io_vga_r, io_vga_g, io_vga_b, io_frame_start} !== 16'hC000) begin
                mismatched++;
                $display("[TB] FAIL reset_state got=%h exp=%h",
                         {io_vga_hsync, io_vga_vsync, io_vga_de, io_vga_r, io_vga_g, io_vga_b, io_frame_start}, 16'hC000);
            end
        end
        reset_n = 1'b1;
        n = 0;
        while (io_vga_de !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
            got = dutVec(); exp = modelVec(edgeCnt);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL reset_release edge=%0d got=%h exp=%h", edgeCnt, got, exp);
            end
        end
        compared++;
        if (n != (LAT + 1) * DIV) begin
            mismatched++;
            $display("[TB] FAIL first_de clocks=%0d exp=%0d", n, (LAT + 1) * DIV);
        end
    endtask

    task automatic test_sync_timing();
        int hFall[$], hRise[$], fsEdge[$];
        int vFall, vRise, deRise, offTick, low;
        logic pH, pV, pD;
        logic [13:0] pOut, cOut;
        logic [VW-1:0] got, exp;
        vFall = -1; vRise = -1; deRise = -1; offTick = 0;
        io_mode = 2'($urandom_range(0, 3));
        pH = io_vga_hsync; pV = io_vga_vsync; pD = io_vga_de;
        pOut = {io_vga_r, io_vga_g, io_vga_b, io_vga_hsync, io_vga_de};
        repeat (2 * FT * DIV + 100) begin
            @(negedge clock);
            got = dutVec(); exp = modelVec(edgeCnt);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL sync_timing edge=%0d got=%h exp=%h", edgeCnt, got, exp);
            end
            if (pH && !io_vga_hsync) hFall.push_back(edgeCnt);
            if (!pH && io_vga_hsync) hRise.push_back(edgeCnt);
            if (pV && !io_vga_vsync && vFall < 0) vFall = edgeCnt;
            if (!pV && io_vga_vsync && vFall >= 0 && vRise < 0) vRise = edgeCnt;
            if (!pD && io_vga_de && deRise < 0) deRise = edgeCnt;
            if (io_frame_start) fsEdge.push_back(edgeCnt);
            cOut = {io_vga_r, io_vga_g, io_vga_b, io_vga_hsync, io_vga_de};
            if (edgeCnt % DIV != 0 && cOut !== pOut) offTick++;
            pH = io_vga_hsync; pV = io_vga_vsync; pD = io_vga_de; pOut = cOut;
        end
        compared++;
        if (hFall.size() < 2 || hFall[1] - hFall[0] != HT * DIV) begin
            mismatched++;
            $display("[TB] FAIL hsync_period got=%0d exp=%0d", hFall.size() < 2 ? -1 : hFall[1] - hFall[0], HT * DIV);
        end
        low = -1;
        foreach (hRise[i]) if (hFall.size() > 0 && low < 0 && hRise[i] > hFall[0]) low = hRise[i] - hFall[0];
        compared++;
        if (low != HS * DIV) begin
            mismatched++;
            $display("[TB] FAIL hsync_low got=%0d exp=%0d", low, HS * DIV);
        end
        low = -1;
        foreach (hFall[i]) if (deRise >= 0 && low < 0 && hFall[i] > deRise) low = hFall[i] - deRise;
        compared++;
        if (low != (HA + HF) * DIV) begin
            mismatched++;
            $display("[TB] FAIL de_to_hsync got=%0d exp=%0d", low, (HA + HF) * DIV);
        end
        compared++;
        if (vFall < 0 || vRise - vFall != VS * HT * DIV) begin
            mismatched++;
            $display("[TB] FAIL vsync_low got=%0d exp=%0d", vRise - vFall, VS * HT * DIV);
        end
        compared++;
        if (fsEdge.size() < 2 || fsEdge[1] - fsEdge[0] != FT * DIV) begin
            mismatched++;
            $display("[TB] FAIL frame_period got=%0d exp=%0d", fsEdge.size() < 2 ? -1 : fsEdge[1] - fsEdge[0], FT * DIV);
        end
        compared++;
        if (offTick != 0) begin
            mismatched++;
            $display("[TB] FAIL off_tick_changes got=%0d exp=0", offTick);
        end
    endtask

    task automatic test_bars_mode_change();
        int n, p, h, v, f;
        bit seen, changed;
        logic [11:0] rgb;
        logic [VW-1:0] got, exp;
        io_mode = 2'd1;
        seen = 0; changed = 0; n = 0;
        // Phase 0: reach a bars frame; phase 1: run it, switching to grid mid-frame.
        for (int phase = 0; phase < 2; phase++) begin
            seen = 0; n = 0;
            while (!seen && n < 3 * FT * DIV) begin
                @(negedge clock);
                n++;
                got = dutVec(); exp = modelVec(edgeCnt);
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL bars_stream edge=%0d got=%h exp=%h", edgeCnt, got, exp);
                end
                p = edgeCnt / DIV - 1 - LAT;
                h = p % HT; v = (p / HT) % VT; f = p / FT;
                rgb = {io_vga_r, io_vga_g, io_vga_b};
                if (phase == 1 && !changed && ((edgeCnt / DIV) / HT) % VT == 10) begin
                    io_mode = 2'd2;
                    changed = 1;
                end
                if (p >= 0 && edgeCnt % DIV == 0 && v < VA && f < 64 && frameMode[f] == 2'd1
                    && (h == 0 || h == 8 || h == 16 || h == 56)) begin
                    compared++;
                    if (rgb !== (h == 0 ? 12'hFFF : h == 8 ? 12'hFF0 : h == 16 ? 12'h0FF : 12'h000)) begin
                        mismatched++;
                        $display("[TB] FAIL bar_pixel x=%0d y=%0d got=%h", h, v, rgb);
                    end
                end
                if (io_frame_start && p >= 0 && f < 64 && (phase == 1 || frameMode[f] == 2'd1)) seen = 1;
            end
            compared++;
            if (!seen) begin
                mismatched++;
                $display("[TB] FAIL bars_frame_wait phase=%0d got=timeout exp=frame_start", phase);
            end
        end
        compared++;
        if ({io_vga_r, io_vga_g, io_vga_b} !== 12'hFFF) begin
            mismatched++;
            $display("[TB] FAIL grid_pixel_0_0 got=%h exp=fff", {io_vga_r, io_vga_g, io_vga_b});
        end
        repeat ((HT + 3) * DIV) begin
            @(negedge clock);
            got = dutVec(); exp = modelVec(edgeCnt);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL grid_stream edge=%0d got=%h exp=%h", edgeCnt, got, exp);
            end
            p = edgeCnt / DIV - 1 - LAT;
            if (edgeCnt % DIV == 0 && p % FT == HT + 1) begin
                compared++;
                if ({io_vga_r, io_vga_g, io_vga_b} !== 12'h000) begin
                    mismatched++;
                    $display("[TB] FAIL grid_pixel_1_1 got=%h exp=000", {io_vga_r, io_vga_g, io_vga_b});
                end
            end
        end
    endtask

    task automatic test_external();
        int n, p, f;
        bit seen;
        logic [VW-1:0] got, exp;
        io_mode = 2'd0;
        seen = 0; n = 0;
        while (!seen && n < 2 * FT * DIV + 100) begin
            @(negedge clock);
            n++;
            got = dutVec(); exp = modelVec(edgeCnt);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL ext_wait edge=%0d got=%h exp=%h", edgeCnt, got, exp);
            end
            p = edgeCnt / DIV - 1 - LAT;
            f = p / FT;
            if (io_frame_start && p >= 0 && f < 64 && frameMode[f] == 2'd0) seen = 1;
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("[TB] FAIL ext_frame_wait got=timeout exp=frame_start");
        end
        repeat (VA * HT * DIV) begin
            @(negedge clock);
            got = dutVec(); exp = modelVec(edgeCnt);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL ext_stream edge=%0d got=%h exp=%h", edgeCnt, got, exp);
            end
            p = edgeCnt / DIV - 1 - LAT;
            if (io_vga_de === 1'b1) begin
                compared++;
                if (io_vga_r !== 4'(p % HT)) begin
                    mismatched++;
                    $display("[TB] FAIL ext_red_column got=%h exp=%h", io_vga_r, 4'(p % HT));
                end
            end
        end
    endtask

    task automatic test_random_modes();
        logic [VW-1:0] got, exp;
        repeat (3 * FT * DIV / 2) begin
            @(negedge clock);
            if ($urandom_range(0, 499) == 0) io_mode = 2'($urandom_range(0, 3));
            got = dutVec(); exp = modelVec(edgeCnt);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL random_modes edge=%0d got=%h exp=%h", edgeCnt, got, exp);
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [VW-1:0] got, exp;
        while (((edgeCnt / DIV - 1 - LAT) % HT) != HA / 2) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        compared++;
        if ({io_vga_hsync, io_vga_vsync, io_vga_de, io_vga_r, io_vga_g, io_vga_b, io_frame_start} !== 16'hC000) begin
            mismatched++;
            $display("[TB] FAIL midline_reset got=%h exp=%h",
                     {io_vga_hsync, io_vga_vsync, io_vga_de, io_vga_r, io_vga_g, io_vga_b, io_frame_start}, 16'hC000);
        end
        io_mode = 2'd2;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3 * HT * DIV) begin
            @(negedge clock);
            got = dutVec(); exp = modelVec(edgeCnt);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL after_midline_reset edge=%0d got=%h exp=%h", edgeCnt, got, exp);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        io_mode    = 2'd0;
        salt       = 4'($urandom);
        test_reset();
        test_sync_timing();
        test_bars_mode_change();
        test_external();
        test_random_modes();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
